// File: rtl/ram_stream_loader.sv
// Byte-stream bus master: buffers stream bytes in a small FIFO and writes them to consecutive RAM offsets.
// One bus write per granted cycle. Input backpressure comes from the FIFO filling or the byte budget running out.

module ram_stream_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign full  = (count == (AW+1)'(2**AW));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
      case ({push && !full, pop && !empty})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ram_stream_loader #(
  parameter int RAMBaseAddr   = 0,
  parameter int RAMAddrWidth  = 7,
  parameter int FIFOAddrWidth = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic [RAMAddrWidth-1:0] START_ADDR,
  input  logic [7:0]              LENGTH,
  input  logic [7:0]              IN_DATA,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic                    BUS_REQ,
  input  logic                    BUS_GNT,
  output logic [7:0]              BUS_ADDR,
  inout  wire  [7:0]              BUS_DATA,
  output logic                    BUS_WE,
  output logic                    BUSY,
  output logic                    DONE
);
  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

  state_t                  state, state_nxt;
  logic [RAMAddrWidth-1:0] offset;
  logic [7:0]              rx_left, wr_left;
  logic                    zero_done, bus_req_q;
  logic                    fifo_full, fifo_empty;
  logic [7:0]              fifo_head;
  logic                    push, wr_en, start_ok, last_write;
  logic [7:0]              addr_int;

  assign start_ok   = (state == IDLE) && START && (LENGTH != 8'd0);
  assign push       = IN_VALID && IN_READY;
  assign last_write = wr_en && (wr_left == 8'd1);
  assign addr_int   = 8'(RAMBaseAddr) + 8'(offset);

  ram_stream_fifo #(.W(8), .AW(FIFOAddrWidth)) u_fifo (
    .clk      (CLK),
    .rst_n    (RESET),
    .push     (push),
    .push_dat (IN_DATA),
    .pop      (wr_en),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)   state_nxt = LOAD;
      LOAD:    if (last_write) state_nxt = FIN;
      FIN:                     state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY     = (state == LOAD);
    DONE     = (state == FIN) || zero_done;
    IN_READY = (state == LOAD) && !fifo_full && (rx_left != 8'd0);
    wr_en    = (state == LOAD) && BUS_GNT && !fifo_empty;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      offset    <= '0;
      rx_left   <= '0;
      wr_left   <= '0;
      zero_done <= 1'b0;
      bus_req_q <= 1'b0;
    end else begin
      zero_done <= (state == IDLE) && START && (LENGTH == 8'd0);
      // Request is held off on the final write so it is already low in FIN.
      bus_req_q <= (state == LOAD) && !fifo_empty && !last_write;
      if (start_ok) begin
        offset  <= START_ADDR;
        rx_left <= LENGTH;
        wr_left <= LENGTH;
      end else begin
        if (push) rx_left <= rx_left - 8'd1;
        if (wr_en) begin
          offset  <= offset + 1'b1;
          wr_left <= wr_left - 8'd1;
        end
      end
    end
  end

  assign BUS_REQ  = bus_req_q;
  // Bus drivers are gated combinationally so a withdrawn grant releases the bus in the same cycle.
  assign BUS_ADDR = BUS_GNT ? addr_int : 8'hzz;
  assign BUS_WE   = BUS_GNT ? wr_en : 1'bz;
  assign BUS_DATA = (BUS_GNT && wr_en) ? fifo_head : 8'hzz;
endmodule

// File: tb/tb_ram_stream_loader.sv
// Scoreboard bench for ram_stream_loader: accepted bytes queue expected bus writes, checked as they appear.
module tb_ram_stream_loader;
  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [6:0] START_ADDR;
  logic [7:0] LENGTH;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;
  logic       BUS_REQ;
  logic       BUS_GNT;
  logic [7:0] BUS_ADDR;
  wire  [7:0] BUS_DATA;
  logic       BUS_WE;
  logic       BUSY;
  logic       DONE;

  ram_stream_loader dut (
    .CLK(CLK), .RESET(RESET), .START(START), .START_ADDR(START_ADDR), .LENGTH(LENGTH),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .BUS_REQ(BUS_REQ),
    .BUS_GNT(BUS_GNT), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_wr_cyc = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  ram [256];
  logic [6:0]  tb_off;
  bit          tog_en = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Bus monitor: the value seen at the falling edge is what the RAM captures at the next rising edge.
  always @(negedge CLK) begin
    if (RESET === 1'b1) begin
      if (DONE === 1'b1) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (BUS_GNT === 1'b1 && BUS_WE === 1'b1) begin
        logic [15:0] e;
        wr_cnt = wr_cnt + 1;
        last_wr_cyc = cyc;
        ram[BUS_ADDR] = BUS_DATA;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write got addr=%h data=%h, expected no write", BUS_ADDR, BUS_DATA);
        end else begin
          e = exp_q.pop_front();
          if ({BUS_ADDR, BUS_DATA} !== e)
            $display("FAIL bus_write got addr=%h data=%h, expected addr=%h data=%h",
                     BUS_ADDR, BUS_DATA, e[15:8], e[7:0]);
          else passes++;
        end
      end
    end
  end

  task automatic start_load(input logic [6:0] a, input logic [7:0] len, input bit track);
    START = 1'b1; START_ADDR = a; LENGTH = len;
    if (track) tb_off = a;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int budget, output bit ok);
    IN_DATA = b; IN_VALID = 1'b1; ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (IN_READY === 1'b1) begin
        exp_q.push_back({tb_off, b});
        tb_off = tb_off + 7'd1;
        @(posedge CLK); #1;
        ok = 1;
        break;
      end
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge CLK); #1;
      if (done_cnt > base) seen = 1;
    end
    checks++;
    if (!seen) $display("FAIL done_timeout got no DONE within %0d cycles, expected DONE", budget);
    else passes++;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drained got %0d pending writes, expected 0", name, exp_q.size());
    else passes++;
    checks++;
    if (BUSY !== 1'b0) $display("FAIL %s_busy_end got %b, expected 0", name, BUSY);
    else passes++;
  endtask

  task automatic test_reset();
    bit ok;
    BUS_GNT = 1'b0;
    start_load(7'h05, 8'd5, 1);
    push_byte(8'h11, 10, ok);
    push_byte(8'h22, 10, ok);
    IN_DATA = 8'h33; IN_VALID = 1'b1;
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if ({IN_READY, BUS_REQ, BUSY, DONE} !== 4'b0000)
        $display("FAIL reset_outputs got rdy/req/busy/done=%b, expected 0000", {IN_READY, BUS_REQ, BUSY, DONE});
      else passes++;
      checks++;
      if (BUS_WE === 1'b1) $display("FAIL reset_bus_we got %b, expected not 1", BUS_WE);
      else passes++;
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b0) $display("FAIL reset_release_ready got %b, expected 0", IN_READY);
    else passes++;
    checks++;
    if (BUSY !== 1'b0) $display("FAIL reset_release_busy got %b, expected 0", BUSY);
    else passes++;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] bytes [3];
    int base = done_cnt;
    bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
    BUS_GNT = 1'b1;
    start_load(7'h10, 8'd3, 1);
    for (int i = 0; i < 3; i++) push_byte(bytes[i], 10, ok);
    wait_done(base, 20);
    checks++;
    if (done_cyc !== last_wr_cyc + 1)
      $display("FAIL basic_done_timing got cycle %0d, expected %0d", done_cyc, last_wr_cyc + 1);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ram[8'h10 + i] !== bytes[i])
        $display("FAIL basic_readback got %h, expected %h at %0d", ram[8'h10 + i], bytes[i], i);
      else passes++;
    end
    check_drained("basic");
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] addrs [4];
    int base = done_cnt;
    addrs[0] = 8'h7E; addrs[1] = 8'h7F; addrs[2] = 8'h00; addrs[3] = 8'h01;
    BUS_GNT = 1'b1;
    start_load(7'h7E, 8'd4, 1);
    for (int i = 0; i < 4; i++) push_byte(8'h50 + 8'(i), 10, ok);
    wait_done(base, 20);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[addrs[i]] !== 8'h50 + 8'(i))
        $display("FAIL wrap_readback got %h, expected %h at addr %h", ram[addrs[i]], 8'h50 + 8'(i), addrs[i]);
      else passes++;
    end
    check_drained("wrap");
  endtask

  task automatic test_no_grant();
    bit ok;
    int acc = 0;
    int w0 = wr_cnt;
    int base = done_cnt;
    BUS_GNT = 1'b0;
    start_load(7'h20, 8'd6, 1);
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h60 + 8'(i), 8, ok);
      if (ok) acc++;
    end
    checks++;
    if (acc != 4) $display("FAIL nogrant_accepted got %0d, expected 4", acc);
    else passes++;
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b0) $display("FAIL nogrant_ready got %b, expected 0", IN_READY);
    else passes++;
    checks++;
    if (BUS_REQ !== 1'b1) $display("FAIL nogrant_req got %b, expected 1", BUS_REQ);
    else passes++;
    checks++;
    if (wr_cnt != w0) $display("FAIL nogrant_writes got %0d, expected 0", wr_cnt - w0);
    else passes++;
    @(posedge CLK); #1;
    BUS_GNT = 1'b1;
    push_byte(8'h64, 10, ok);
    push_byte(8'h65, 10, ok);
    wait_done(base, 20);
    checks++;
    if (wr_cnt - w0 != 6) $display("FAIL nogrant_total got %0d writes, expected 6", wr_cnt - w0);
    else passes++;
    check_drained("nogrant");
  endtask

  task automatic test_toggle();
    bit ok;
    int w0 = wr_cnt;
    int base = done_cnt;
    BUS_GNT = 1'b0;
    start_load(7'h30, 8'd8, 1);
    tog_en = 1;
    fork
      begin
        while (tog_en) begin
          @(posedge CLK); #1;
          BUS_GNT = ~BUS_GNT;
        end
      end
    join_none
    for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i), 20, ok);
    push_byte(8'h99, 6, ok);
    checks++;
    if (ok) $display("FAIL toggle_ninth got accepted, expected refused");
    else passes++;
    wait_done(base, 40);
    tog_en = 0;
    @(posedge CLK); #2;
    BUS_GNT = 1'b1;
    checks++;
    if (wr_cnt - w0 != 8) $display("FAIL toggle_writes got %0d, expected 8", wr_cnt - w0);
    else passes++;
    exp_q.delete();
    check_drained("toggle");
  endtask

  task automatic test_zero_and_ignore();
    bit ok;
    int base;
    BUS_GNT = 1'b1;
    start_load(7'h30, 8'd0, 0);
    @(negedge CLK);
    checks++;
    if ({DONE, BUSY, BUS_REQ} !== 3'b100)
      $display("FAIL zero_len got done/busy/req=%b, expected 100", {DONE, BUSY, BUS_REQ});
    else passes++;
    @(negedge CLK);
    checks++;
    if ({DONE, BUSY, BUS_REQ} !== 3'b000)
      $display("FAIL zero_len_after got done/busy/req=%b, expected 000", {DONE, BUSY, BUS_REQ});
    else passes++;
    @(posedge CLK); #1;
    base = done_cnt;
    ram[8'h50] = 8'h00;
    start_load(7'h40, 8'd2, 1);
    push_byte(8'hD1, 10, ok);
    checks++;
    if (BUSY !== 1'b1) $display("FAIL ignore_busy got %b, expected 1", BUSY);
    else passes++;
    start_load(7'h50, 8'd3, 0);
    push_byte(8'hD2, 10, ok);
    wait_done(base, 20);
    checks++;
    if (ram[8'h41] !== 8'hD2 || ram[8'h50] !== 8'h00)
      $display("FAIL ignore_start got ram41=%h ram50=%h, expected D2 00", ram[8'h41], ram[8'h50]);
    else passes++;
    check_drained("ignore");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    RESET = 1'b0; START = 1'b0; START_ADDR = '0; LENGTH = '0;
    IN_DATA = '0; IN_VALID = 1'b0; BUS_GNT = 1'b0; tb_off = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    test_reset();
    test_basic();
    test_wrap();
    test_no_grant();
    test_toggle();
    test_zero_and_ignore();
    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
